// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, default width, output FSM states
// and the modulo-increment helper used for the round-robin pointer.
package alu_arbiter_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_NOT = 3'd2;
    localparam logic [2:0] ALU_SHL = 3'd3;
    localparam logic [2:0] ALU_SHR = 3'd4;
    localparam logic [2:0] ALU_AND = 3'd5;
    localparam logic [2:0] ALU_OR  = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        if (idx >= n - 1) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin grant: first asserted request scanning upward from ptr, wrapping mod NREQ.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    logic [IDW-1:0] cand_s;

    // Scan candidates ptr, ptr+1, ... and latch onto the first valid one
    always_comb begin
        grant     = {NREQ{1'b0}};
        grant_idx = {IDW{1'b0}};
        grant_any = 1'b0;
        cand_s    = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
                grant_any     = 1'b1;
            end else begin
                grant_any = grant_any;
            end
            cand_s = IDW'(wrap_inc(int'(cand_s), NREQ));
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational 16-bit ALU between NREQ requesters with round-robin
// arbitration and a single registered, id-tagged response slot.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int NREQ  = 2,
    parameter int IDW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero
);

    out_state_t       state_r;
    logic [IDW-1:0]   ptr_r;
    logic [IDW-1:0]   rsp_id_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic             rsp_zero_r;

    logic [NREQ-1:0]  grant_s;
    logic [IDW-1:0]   grant_idx_s;
    logic             grant_any_s;
    logic             can_accept_s;
    logic [NREQ-1:0]  req_ready_s;
    logic             xfer_s;
    logic [WIDTH-1:0] alu_a_s;
    logic [WIDTH-1:0] alu_b_s;
    logic [2:0]       alu_op_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_zero_s;
    logic [IDW-1:0]   next_ptr_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // Grant is only offered when the response slot is free or draining this edge
    always_comb begin
        can_accept_s = (state_r == ST_EMPTY) || rsp_ready;
        if (rst) begin
            req_ready_s = {NREQ{1'b0}};
        end else if (can_accept_s && grant_any_s) begin
            req_ready_s = grant_s;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
        xfer_s     = |req_ready_s;
        next_ptr_s = IDW'(wrap_inc(int'(grant_idx_s), NREQ));
    end

    // Operand mux, held at zero when nothing transfers to keep the ALU quiet
    always_comb begin
        if (xfer_s) begin
            alu_a_s  = req_a[int'(grant_idx_s)*WIDTH +: WIDTH];
            alu_b_s  = req_b[int'(grant_idx_s)*WIDTH +: WIDTH];
            alu_op_s = req_op[int'(grant_idx_s)*3 +: 3];
        end else begin
            alu_a_s  = {WIDTH{1'b0}};
            alu_b_s  = {WIDTH{1'b0}};
            alu_op_s = 3'd0;
        end
    end

    // Shared ALU datapath
    always_comb begin
        case (alu_op_s)
            ALU_ADD: alu_res_s = alu_a_s + alu_b_s;
            ALU_SUB: alu_res_s = alu_a_s - alu_b_s;
            ALU_NOT: alu_res_s = ~alu_a_s;
            ALU_SHL: alu_res_s = alu_a_s << alu_b_s;
            ALU_SHR: alu_res_s = alu_a_s >> alu_b_s;
            ALU_AND: alu_res_s = alu_a_s & alu_b_s;
            ALU_OR:  alu_res_s = alu_a_s | alu_b_s;
            ALU_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, (alu_a_s < alu_b_s)};
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
        alu_zero_s = (alu_res_s == {WIDTH{1'b0}});
    end

    // Output slot FSM, response registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_EMPTY;
            ptr_r        <= {IDW{1'b0}};
            rsp_id_r     <= {IDW{1'b0}};
            rsp_result_r <= {WIDTH{1'b0}};
            rsp_zero_r   <= 1'b0;
        end else begin
            if (xfer_s) begin
                rsp_id_r     <= grant_idx_s;
                rsp_result_r <= alu_res_s;
                rsp_zero_r   <= alu_zero_s;
                ptr_r        <= next_ptr_s;
            end else begin
                ptr_r <= ptr_r;
            end
            case (state_r)
                ST_EMPTY: state_r <= xfer_s ? ST_FULL : ST_EMPTY;
                ST_FULL:  state_r <= (xfer_s || !rsp_ready) ? ST_FULL : ST_EMPTY;
                default:  state_r <= ST_EMPTY;
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign rsp_valid  = (state_r == ST_FULL);
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign rsp_zero   = rsp_zero_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: the driver pushes hand-computed responses into a
// queue as grants occur, and an independent monitor pops and compares delivered responses.
module tb_alu_arbiter;

    localparam int W   = 16;
    localparam int N   = 2;
    localparam int IDW = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*3-1:0] req_op;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_zero;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   res;
        logic           z;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic stall_r = 1'b0;
    rsp_t snap_r;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i*3 +: 3] = op;
    endtask

    // Called at posedge+1; checks the grant mid-cycle and records the expected response
    task automatic step(input logic [N-1:0] exp_rdy, input logic [IDW-1:0] eid,
                        input logic [W-1:0] eres, input string nm);
        rsp_t e;
        @(negedge clk);
        check(nm, 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != '0) begin
            e.id  = eid;
            e.res = eres;
            e.z   = (eres == 16'h0000);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on each consumed response, checks stability while stalled
    always @(negedge clk) begin
        rsp_t e;
        rsp_t cur;
        cur = '{id: rsp_id, res: rsp_result, z: rsp_zero};
        if (rst) begin
            stall_r <= 1'b0;
        end else if (rsp_valid) begin
            if (stall_r) begin
                check("rsp_stable", 32'(cur), 32'(snap_r));
            end
            if (rsp_ready) begin
                stall_r <= 1'b0;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_result", 32'(rsp_result), 32'(e.res));
                    check("rsp_zero", 32'(rsp_zero), 32'(e.z));
                end
            end else begin
                stall_r <= 1'b1;
                snap_r  <= cur;
            end
        end else begin
            stall_r <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'(2'b00));
        check("rst_valid", 32'(rsp_valid), 32'(1'b0));
        check("rst_id", 32'(rsp_id), 32'(1'b0));
        check("rst_result", 32'(rsp_result), 32'(16'h0000));
        check("rst_zero", 32'(rsp_zero), 32'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request, then flag/wrap/opcode vectors alternating requesters
        set_req(0, 16'd5, 16'd3, 3'd0); req_valid = 2'b01; step(2'b01, 1'b0, 16'd8, "single");
        req_valid = 2'b00; step(2'b00, 1'b0, 16'd0, "idle");
        set_req(0, 16'hFFFF, 16'h0001, 3'd0); req_valid = 2'b01; step(2'b01, 1'b0, 16'h0000, "add_wrap");
        set_req(1, 16'h0002, 16'h0003, 3'd7); req_valid = 2'b10; step(2'b10, 1'b1, 16'h0001, "slt_true");
        set_req(0, 16'h0001, 16'h0004, 3'd3); req_valid = 2'b01; step(2'b01, 1'b0, 16'h0010, "shl");
        set_req(1, 16'h00F0, 16'h0F0F, 3'd5); req_valid = 2'b10; step(2'b10, 1'b1, 16'h0000, "and_zero");
        set_req(0, 16'h1234, 16'h1235, 3'd1); req_valid = 2'b01; step(2'b01, 1'b0, 16'hFFFF, "sub_wrap");
        set_req(1, 16'h8000, 16'h000F, 3'd4); req_valid = 2'b10; step(2'b10, 1'b1, 16'h0001, "shr");
        set_req(0, 16'h00F0, 16'h0000, 3'd2); req_valid = 2'b01; step(2'b01, 1'b0, 16'hFF0F, "not");
        set_req(1, 16'h0F00, 16'h00F0, 3'd6); req_valid = 2'b10; step(2'b10, 1'b1, 16'h0FF0, "or");
        set_req(0, 16'h0003, 16'h0002, 3'd7); req_valid = 2'b01; step(2'b01, 1'b0, 16'h0000, "slt_false");

        // Contention from ptr=1: grants alternate 1,0,1,0
        set_req(0, 16'd10, 16'd1, 3'd0);
        set_req(1, 16'd20, 16'd5, 3'd1);
        req_valid = 2'b11;
        step(2'b10, 1'b1, 16'd15, "cont_g1");
        step(2'b01, 1'b0, 16'd11, "cont_g0");
        step(2'b10, 1'b1, 16'd15, "cont_g1b");
        step(2'b01, 1'b0, 16'd11, "cont_g0b");

        // Backpressure: fill, stall three cycles, then drain and accept on the same edge
        step(2'b10, 1'b1, 16'd15, "bp_fill");
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 16'd0, "bp_stall");
        rsp_ready = 1'b1;
        step(2'b01, 1'b0, 16'd11, "bp_drain");
        req_valid = 2'b00; step(2'b00, 1'b0, 16'd0, "bp_idle");

        // Fairness: ptr=1, lone req1 granted, then req0 is served before req1 again
        req_valid = 2'b10; step(2'b10, 1'b1, 16'd15, "fair_r1");
        req_valid = 2'b11; step(2'b01, 1'b0, 16'd11, "fair_r0");
        step(2'b10, 1'b1, 16'd15, "fair_r1b");
        req_valid = 2'b00; step(2'b00, 1'b0, 16'd0, "fair_idle");

        // Reset while a response is held and a request is pending
        req_valid = 2'b01; step(2'b01, 1'b0, 16'd11, "pre_rst");
        rsp_ready = 1'b0; req_valid = 2'b11; step(2'b00, 1'b0, 16'd0, "full_block");
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 32'(req_ready), 32'(2'b00));
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 32'(rsp_valid), 32'(1'b0));
        @(posedge clk); #1;
        req_valid = 2'b11; step(2'b01, 1'b0, 16'd11, "post_rst_g0");
        req_valid = 2'b00; step(2'b00, 1'b0, 16'd0, "post_idle");
        step(2'b00, 1'b0, 16'd0, "post_idle2");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
